// File: rtl/param_defs.sv
// Shared widths and the hazard-controller state type for the RV32 pipeline.
package param_defs;

   localparam int unsigned RegAddrWidth  = 5;
   localparam int unsigned NumRegs       = 32;
   localparam int unsigned PcWidth       = 32;
   localparam int unsigned ScoreCntWidth = 6;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DRAIN,
      TRAP_JUMP
   } hctl_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-destination scoreboard for long-latency results.
// Provides writeback bypass on lookups, set-wins update, and a popcount.
module hazard_scoreboard
   import param_defs::*;
#(
   parameter int unsigned AddrWidth = RegAddrWidth,
   parameter int unsigned Depth     = NumRegs
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     set_en,
   input  logic [AddrWidth-1:0]     set_addr,
   input  logic                     clr_en,
   input  logic [AddrWidth-1:0]     clr_addr,
   input  logic [AddrWidth-1:0]     rs1_addr,
   input  logic [AddrWidth-1:0]     rs2_addr,
   input  logic [AddrWidth-1:0]     rd_addr,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic                     rd_busy,
   output logic                     any_busy,
   output logic [ScoreCntWidth-1:0] cnt
);

   logic [Depth-1:0]         pending;
   logic [Depth-1:0]         pending_nxt;
   logic [Depth-1:0]         eff;
   logic [ScoreCntWidth-1:0] cnt_nxt;

   // A register being written back this cycle is already visible through the regfile.
   always_comb begin
      eff = pending;
      if (clr_en) eff[clr_addr] = 1'b0;
      eff[0] = 1'b0;
   end

   assign rs1_busy = eff[rs1_addr];
   assign rs2_busy = eff[rs2_addr];
   assign rd_busy  = eff[rd_addr];
   assign any_busy = |eff;

   // Clear first, then set, so a same-cycle set of the same register wins.
   always_comb begin
      pending_nxt = pending;
      if (clr_en) pending_nxt[clr_addr] = 1'b0;
      if (set_en && (set_addr != '0)) pending_nxt[set_addr] = 1'b1;
      pending_nxt[0] = 1'b0;
      cnt_nxt = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
         cnt_nxt = cnt_nxt + ScoreCntWidth'(pending_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         cnt     <= '0;
      end else begin
         pending <= pending_nxt;
         cnt     <= cnt_nxt;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW/WAW stalls against the scoreboard,
// issue into EX, branch-redirect flushes and precise trap entry.
module pipe_hazard_ctrl #(
   parameter int unsigned RegAddrWidth = param_defs::RegAddrWidth,
   parameter int unsigned NumRegs      = param_defs::NumRegs,
   parameter int unsigned PcWidth      = param_defs::PcWidth
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 id_valid,
   input  logic [RegAddrWidth-1:0]              id_rs1_addr,
   input  logic [RegAddrWidth-1:0]              id_rs2_addr,
   input  logic                                 id_rs1_used,
   input  logic                                 id_rs2_used,
   input  logic [RegAddrWidth-1:0]              id_rd_addr,
   input  logic                                 id_rd_en,
   input  logic                                 id_long_lat,
   input  logic                                 wb_valid,
   input  logic [RegAddrWidth-1:0]              wb_rd_addr,
   input  logic                                 redirect_req,
   input  logic [PcWidth-1:0]                   redirect_pc,
   input  logic                                 trap_req,
   input  logic [PcWidth-1:0]                   trap_vec,
   output logic                                 issue,
   output logic                                 stall_if,
   output logic                                 stall_id,
   output logic                                 flush_if,
   output logic                                 flush_id,
   output logic                                 pc_redirect_en,
   output logic [PcWidth-1:0]                   pc_redirect_addr,
   output logic [param_defs::ScoreCntWidth-1:0] pending_cnt
);

   param_defs::hctl_state_e              state;
   logic                                 started;
   logic [PcWidth-1:0]                   vec;
   logic                                 rs1_busy;
   logic                                 rs2_busy;
   logic                                 rd_busy;
   logic                                 any_busy;
   logic                                 hazard;
   logic                                 issue_ok;
   logic [param_defs::ScoreCntWidth-1:0] sb_cnt;

   assign hazard = id_valid & ((id_rs1_used & rs1_busy) |
                               (id_rs2_used & rs2_busy) |
                               (id_rd_en & rd_busy));

   assign issue_ok = started & (state == param_defs::RUN) & id_valid & ~hazard &
                     ~redirect_req & ~trap_req;

   hazard_scoreboard #(
      .AddrWidth (RegAddrWidth),
      .Depth     (NumRegs)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue_ok & id_long_lat & id_rd_en),
      .set_addr (id_rd_addr),
      .clr_en   (wb_valid),
      .clr_addr (wb_rd_addr),
      .rs1_addr (id_rs1_addr),
      .rs2_addr (id_rs2_addr),
      .rd_addr  (id_rd_addr),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .rd_busy  (rd_busy),
      .any_busy (any_busy),
      .cnt      (sb_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         state   <= param_defs::RUN;
         vec     <= '0;
      end else begin
         started <= 1'b1;
         if (started) begin
            unique case (state)
               param_defs::RUN: begin
                  if (trap_req) begin
                     vec   <= trap_vec;
                     state <= param_defs::DRAIN;
                  end else if (redirect_req) begin
                     state <= param_defs::FLUSH;
                  end
               end
               param_defs::FLUSH: begin
                  if (trap_req) begin
                     vec   <= trap_vec;
                     state <= param_defs::DRAIN;
                  end else begin
                     state <= param_defs::RUN;
                  end
               end
               param_defs::DRAIN: begin
                  // Leave once every owed result has landed, counting this cycle's writeback.
                  if (!any_busy) state <= param_defs::TRAP_JUMP;
               end
               param_defs::TRAP_JUMP: state <= param_defs::FLUSH;
            endcase
         end
      end
   end

   always_comb begin
      issue            = issue_ok;
      stall_if         = 1'b0;
      stall_id         = 1'b0;
      flush_if         = 1'b0;
      flush_id         = 1'b0;
      pc_redirect_en   = 1'b0;
      pc_redirect_addr = '0;
      if (!started) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
      end else begin
         unique case (state)
            param_defs::RUN: begin
               if (trap_req) begin
                  stall_if = 1'b1;
                  flush_id = 1'b1;
               end else if (redirect_req) begin
                  pc_redirect_en   = 1'b1;
                  pc_redirect_addr = redirect_pc;
                  flush_if         = 1'b1;
                  flush_id         = 1'b1;
               end else if (hazard) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
               end
            end
            param_defs::FLUSH: flush_id = 1'b1;
            param_defs::DRAIN: begin
               stall_if = 1'b1;
               flush_id = 1'b1;
            end
            param_defs::TRAP_JUMP: begin
               pc_redirect_en   = 1'b1;
               pc_redirect_addr = vec;
               flush_if         = 1'b1;
               flush_id         = 1'b1;
            end
         endcase
      end
   end

   assign pending_cnt = started ? sb_cnt : '0;

endmodule
